// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mips_pkg                                                       |
// | Purpose : Shared types and constants for the MIPS data-memory path:      |
// |           responder FSM state encoding, decode targets, default MMIO     |
// |           byte addresses and the address-decode helper.                  |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   typedef enum logic [1:0] {
      TGT_ERR = 2'd0,
      TGT_LED = 2'd1,
      TGT_SW  = 2'd2,
      TGT_RAM = 2'd3
   } dmem_target_t;

   localparam logic [31:0] c_LED_ADDR_DEFAULT = 32'hFFFF_FF00;
   localparam logic [31:0] c_SW_ADDR_DEFAULT  = 32'hFFFF_FF04;

   // Priority decode: misalignment first, then the MMIO registers (so they
   // win over any overlap with RAM), then the RAM window. ramBytes is one bit
   // wider than the address so a 2^30-word RAM still has a representable end.
   function automatic dmem_target_t dmemDecode(
      input logic [31:0] addr,
      input logic        write,
      input logic [31:0] ledAddr,
      input logic [31:0] swAddr,
      input logic [32:0] ramBytes
   );
      dmem_target_t tgt;
      if (addr[1:0] != 2'b00) begin
         tgt = TGT_ERR;
      end else if (addr == ledAddr) begin
         tgt = TGT_LED;
      end else if (addr == swAddr) begin
         tgt = write ? TGT_ERR : TGT_SW;
      end else if ({1'b0, addr} < ramBytes) begin
         tgt = TGT_RAM;
      end else begin
         tgt = TGT_ERR;
      end
      return tgt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_responder_if                                              |
// | Purpose : Load/store request-response bundle between the CPU M-stage     |
// |           (master) and the data-memory responder (slave).                |
// | Signals : ReqValid/ReqReady handshake, ReqWrite, ReqAddr[31:0],          |
// |           ReqWrData[31:0]; RespValid pulse, RespRdData[31:0], RespErr.   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface dmem_responder_if;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [31:0] ReqAddr;
   logic [31:0] ReqWrData;
   logic        RespValid;
   logic [31:0] RespRdData;
   logic        RespErr;

   modport master (
      output ReqValid, ReqWrite, ReqAddr, ReqWrData,
      input  ReqReady, RespValid, RespRdData, RespErr
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqAddr, ReqWrData,
      output ReqReady, RespValid, RespRdData, RespErr
   );
endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_ram                                                       |
// | Purpose : Single-port synchronous word RAM, 2^ADDR_W x 32, no reset,     |
// |           written so it maps onto block RAM. Read is registered and      |
// |           returns the old word on a write cycle.                         |
// | Ports   : Clk, we, addr[ADDR_W-1:0], wdata[31:0] -> rdata[31:0]          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dmem_ram #(
   parameter int unsigned ADDR_W = 8
) (
   input  wire logic              Clk,
   input  wire logic              we,
   input  wire logic [ADDR_W-1:0] addr,
   input  wire logic [31:0]       wdata,
   output logic      [31:0]       rdata
);

   logic [31:0] r_mem [0:(1 << ADDR_W) - 1];

   always_ff @(posedge Clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
      rdata <= r_mem[addr];
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_responder                                                 |
// | Purpose : Memory end of the MIPS data-memory interface. Accepts one      |
// |           word request at a time, waits WAIT_CYCLES, then responds from  |
// |           the word RAM, the LED register or the synchronised switches.   |
// | Ports   : Clk, Rst (async, active-low)                                   |
// |           bus     : dmem_responder_if.slave request/response bundle      |
// |           switch  : 8-bit board switch input (asynchronous)              |
// |           led     : 8-bit LED register output                            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dmem_responder
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] LED_ADDR    = c_LED_ADDR_DEFAULT,
   parameter logic [31:0] SW_ADDR     = c_SW_ADDR_DEFAULT
) (
   input  wire logic         Clk,
   input  wire logic         Rst,
   dmem_responder_if.slave   bus,
   input  wire logic [7:0]   switch,
   output logic      [7:0]   led
);

   localparam logic [32:0] c_RAM_BYTES = 33'd4 << ADDR_W;
   localparam logic [3:0]  c_LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   dmem_state_t  r_state;
   dmem_state_t  w_stateNext;
   logic [3:0]   r_waitCnt;
   logic [3:0]   w_waitCntNext;
   logic         w_enterResp;
   logic         w_reqReady;
   logic         w_respValid;
   logic         w_accept;

   logic         r_write;
   logic [31:0]  r_addr;
   logic [31:0]  r_wrData;

   logic         w_opWrite;
   logic [31:0]  w_opAddr;
   logic [31:0]  w_opWrData;
   dmem_target_t w_target;

   logic [31:0]  r_rdData;
   logic         r_err;
   logic         r_rdFromRam;
   logic [7:0]   r_led;
   logic [7:0]   r_swMeta;
   logic [7:0]   r_swSync;

   logic         w_ramWe;
   logic [31:0]  w_ramRdata;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state   <= IDLE;
         r_waitCnt <= 4'd0;
      end else begin
         r_state   <= w_stateNext;
         r_waitCnt <= w_waitCntNext;
      end
   end

   always_comb begin
      w_stateNext   = r_state;
      w_waitCntNext = 4'd0;
      w_enterResp   = 1'b0;
      w_reqReady    = 1'b0;
      w_respValid   = 1'b0;
      case (r_state)
         IDLE: begin
            w_reqReady = 1'b1;
            if (bus.ReqValid) begin
               if (WAIT_CYCLES == 0) begin
                  w_stateNext = RESP;
                  w_enterResp = 1'b1;
               end else begin
                  w_stateNext = BUSY;
               end
            end
         end
         BUSY: begin
            if (r_waitCnt == c_LAST_WAIT) begin
               w_stateNext = RESP;
               w_enterResp = 1'b1;
            end else begin
               w_waitCntNext = r_waitCnt + 4'd1;
            end
         end
         RESP: begin
            w_respValid = 1'b1;
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   assign w_accept = bus.ReqValid && (r_state == IDLE);

   // ------------------------------------------------------ request latch
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_write  <= 1'b0;
         r_addr   <= 32'd0;
         r_wrData <= 32'd0;
      end else if (w_accept) begin
         r_write  <= bus.ReqWrite;
         r_addr   <= bus.ReqAddr;
         r_wrData <= bus.ReqWrData;
      end
   end

   // With zero wait states the response is decided on the accept edge
   // itself, before the latch holds anything, so in IDLE the live request
   // is used; every other state works from the latched copy.
   assign w_opWrite  = (r_state == IDLE) ? bus.ReqWrite  : r_write;
   assign w_opAddr   = (r_state == IDLE) ? bus.ReqAddr   : r_addr;
   assign w_opWrData = (r_state == IDLE) ? bus.ReqWrData : r_wrData;

   assign w_target = dmemDecode(w_opAddr, w_opWrite, LED_ADDR, SW_ADDR, c_RAM_BYTES);

   // ---------------------------------------------------------------- RAM
   assign w_ramWe = w_enterResp && (w_target == TGT_RAM) && w_opWrite;

   dmem_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .Clk    (Clk),
      .we     (w_ramWe),
      .addr   (w_opAddr[ADDR_W+1:2]),
      .wdata  (w_opWrData),
      .rdata  (w_ramRdata)
   );

   // ---------------------------------------------- switch synchroniser
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_swMeta <= 8'd0;
         r_swSync <= 8'd0;
      end else begin
         r_swMeta <= switch;
         r_swSync <= r_swMeta;
      end
   end

   // ------------------------------------------- response / MMIO commit
   // The RAM read is registered on the edge entering RESP, the same edge
   // that captures MMIO data, so during RESP a RAM load is forwarded
   // straight from the RAM output and copied into r_rdData on the way out
   // of RESP; that keeps the value held after RespValid falls.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_rdData    <= 32'd0;
         r_err       <= 1'b0;
         r_rdFromRam <= 1'b0;
         r_led       <= 8'd0;
      end else if (w_enterResp) begin
         r_err       <= 1'b0;
         r_rdData    <= 32'd0;
         r_rdFromRam <= 1'b0;
         case (w_target)
            TGT_LED: begin
               if (w_opWrite) begin
                  r_led <= w_opWrData[7:0];
               end else begin
                  r_rdData <= {24'd0, r_led};
               end
            end
            TGT_SW: begin
               r_rdData <= {24'd0, r_swSync};
            end
            TGT_RAM: begin
               r_rdFromRam <= !w_opWrite;
            end
            default: begin
               r_err <= 1'b1;
            end
         endcase
      end else if (r_rdFromRam) begin
         r_rdData    <= w_ramRdata;
         r_rdFromRam <= 1'b0;
      end
   end

   // ------------------------------------------------------------ outputs
   assign bus.ReqReady   = w_reqReady;
   assign bus.RespValid  = w_respValid;
   assign bus.RespRdData = r_rdFromRam ? w_ramRdata : r_rdData;
   assign bus.RespErr    = r_err;
   assign led            = r_led;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dmem_responder                                              |
// | Purpose : Directed self-checking bench for dmem_responder. One instance  |
// |           with default parameters (2 wait states) and one with zero      |
// |           wait states, driven from a single linear initial block.        |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

   localparam logic [31:0] c_LED = 32'hFFFF_FF00;
   localparam logic [31:0] c_SW  = 32'hFFFF_FF04;

   logic       Clk = 1'b0;
   logic       rstA;
   logic       rstB;
   logic [7:0] swA;
   logic [7:0] swB;
   logic [7:0] ledA;
   logic [7:0] ledB;

   int nVec = 0;
   int nMis = 0;

   dmem_responder_if busA ();
   dmem_responder_if busB ();

   dmem_responder #(
      .ADDR_W      (8),
      .WAIT_CYCLES (2)
   ) dut (
      .Clk    (Clk),
      .Rst    (rstA),
      .bus    (busA),
      .switch (swA),
      .led    (ledA)
   );

   dmem_responder #(
      .ADDR_W      (8),
      .WAIT_CYCLES (0)
   ) dut0 (
      .Clk    (Clk),
      .Rst    (rstB),
      .bus    (busB),
      .switch (swB),
      .led    (ledB)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request on instance A (which=0) or B (which=1). lat counts cycles
   // from the accept edge to the cycle where RespValid is seen (-1 = none).
   task automatic txn(input bit which, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic err, output int lat, output logic [7:0] ledResp);
      logic rv;
      @(negedge Clk);
      if (which) begin
         busB.ReqValid = 1'b1; busB.ReqWrite = wr; busB.ReqAddr = addr; busB.ReqWrData = wdata;
      end else begin
         busA.ReqValid = 1'b1; busA.ReqWrite = wr; busA.ReqAddr = addr; busA.ReqWrData = wdata;
      end
      @(posedge Clk);
      #1;
      busA.ReqValid = 1'b0;
      busB.ReqValid = 1'b0;
      lat = -1; rd = 32'd0; err = 1'b0; ledResp = 8'd0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge Clk);
         rv = which ? busB.RespValid : busA.RespValid;
         if (rv) begin
            lat     = k;
            rd      = which ? busB.RespRdData : busA.RespRdData;
            err     = which ? busB.RespErr    : busA.RespErr;
            ledResp = which ? ledB : ledA;
            break;
         end
      end
      @(negedge Clk);
      check("pulse_width", 32'(which ? busB.RespValid : busA.RespValid), 32'd0);
   endtask

   logic [31:0] rd;
   logic        err;
   int          lat;
   logic [7:0]  ledR;
   int          accepts, pulses, maxW, curW, overlap, readyLow;
   logic [31:0] rdAt11;

   initial begin
      busA.ReqValid = 1'b0; busA.ReqWrite = 1'b0; busA.ReqAddr = 32'd0; busA.ReqWrData = 32'd0;
      busB.ReqValid = 1'b0; busB.ReqWrite = 1'b0; busB.ReqAddr = 32'd0; busB.ReqWrData = 32'd0;
      swA = 8'd0; swB = 8'd0;
      rstA = 1'b1; rstB = 1'b1;
      #2;
      rstA = 1'b0; rstB = 1'b0;
      repeat (2) @(negedge Clk);

      // Reset state
      check("rst_ready_A",  32'(busA.ReqReady),  32'd1);
      check("rst_rvalid_A", 32'(busA.RespValid), 32'd0);
      check("rst_rdata_A",  busA.RespRdData,     32'd0);
      check("rst_err_A",    32'(busA.RespErr),   32'd0);
      check("rst_led_A",    32'(ledA),           32'd0);
      check("rst_ready_B",  32'(busB.ReqReady),  32'd1);
      check("rst_rvalid_B", 32'(busB.RespValid), 32'd0);
      rstA = 1'b1; rstB = 1'b1;

      // Store then load
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, lat, ledR);
      check("st10_lat",   32'(lat), 32'd3);
      check("st10_err",   32'(err), 32'd0);
      check("st10_rdata", rd,       32'd0);
      txn(0, 1'b0, 32'h10, 32'd0, rd, err, lat, ledR);
      check("ld10_lat",   32'(lat), 32'd3);
      check("ld10_rdata", rd,       32'hDEADBEEF);
      check("ld10_hold",  busA.RespRdData, 32'hDEADBEEF);

      // Misaligned, out of range
      txn(0, 1'b1, 32'h13, 32'h1, rd, err, lat, ledR);
      check("st13_err", 32'(err), 32'd1);
      txn(0, 1'b0, 32'h10, 32'd0, rd, err, lat, ledR);
      check("ld10_after_mis", rd, 32'hDEADBEEF);
      txn(0, 1'b0, 32'h400, 32'd0, rd, err, lat, ledR);
      check("ld400_err",   32'(err), 32'd1);
      check("ld400_rdata", rd,       32'd0);
      @(negedge Clk);
      check("ld400_err_hold", 32'(busA.RespErr), 32'd1);

      // Top RAM word
      txn(0, 1'b1, 32'h3FC, 32'h12345678, rd, err, lat, ledR);
      check("st3fc_err", 32'(err), 32'd0);
      txn(0, 1'b0, 32'h3FC, 32'd0, rd, err, lat, ledR);
      check("ld3fc_rdata", rd, 32'h12345678);

      // MMIO
      txn(0, 1'b1, c_LED, 32'h0000_00A5, rd, err, lat, ledR);
      check("stled_at_resp", 32'(ledR), 32'hA5);
      check("stled_err",     32'(err),  32'd0);
      txn(0, 1'b0, c_LED, 32'd0, rd, err, lat, ledR);
      check("ldled_rdata", rd, 32'h0000_00A5);
      swA = 8'h3C;
      repeat (3) @(negedge Clk);
      txn(0, 1'b0, c_SW, 32'd0, rd, err, lat, ledR);
      check("ldsw_rdata", rd,       32'h0000_003C);
      check("ldsw_err",   32'(err), 32'd0);
      txn(0, 1'b1, c_SW, 32'h55, rd, err, lat, ledR);
      check("stsw_err", 32'(err), 32'd1);
      check("stsw_led", 32'(ledA), 32'hA5);

      // Handshake with ReqValid held high: accepts at edges 0, 4, 8
      @(negedge Clk);
      busA.ReqValid = 1'b1; busA.ReqWrite = 1'b0; busA.ReqAddr = 32'h10;
      accepts = 0; pulses = 0; maxW = 0; curW = 0; overlap = 0; readyLow = 0; rdAt11 = 32'd0;
      for (int i = 0; i < 12; i++) begin
         if (busA.ReqValid && busA.ReqReady) accepts++;
         if (!busA.ReqReady) readyLow++;
         if (busA.RespValid) begin
            curW++;
            if (curW == 1) pulses++;
            if (curW > maxW) maxW = curW;
            if (busA.ReqReady) overlap++;
         end else begin
            curW = 0;
         end
         if (i == 11) begin
            rdAt11 = busA.RespRdData;
            busA.ReqValid = 1'b0;
         end
         @(negedge Clk);
      end
      check("hs_accepts",  32'(accepts),  32'd3);
      check("hs_pulses",   32'(pulses),   32'd3);
      check("hs_maxwidth", 32'(maxW),     32'd1);
      check("hs_overlap",  32'(overlap),  32'd0);
      check("hs_readylow", 32'(readyLow), 32'd9);
      check("hs_rdata",    rdAt11,        32'hDEADBEEF);

      // Zero wait states
      txn(1, 1'b1, 32'h0, 32'hCAFEF00D, rd, err, lat, ledR);
      check("w0_st_lat", 32'(lat), 32'd1);
      check("w0_st_err", 32'(err), 32'd0);
      txn(1, 1'b0, 32'h0, 32'd0, rd, err, lat, ledR);
      check("w0_ld_lat",   32'(lat), 32'd1);
      check("w0_ld_rdata", rd,       32'hCAFEF00D);
      check("w0_ld_hold",  busB.RespRdData, 32'hCAFEF00D);

      // Reset during BUSY of a store to 0x20
      txn(0, 1'b1, 32'h20, 32'h0, rd, err, lat, ledR);
      @(negedge Clk);
      busA.ReqValid = 1'b1; busA.ReqWrite = 1'b1; busA.ReqAddr = 32'h20; busA.ReqWrData = 32'h11223344;
      @(posedge Clk);
      #1;
      busA.ReqValid = 1'b0;
      @(negedge Clk);
      check("mid_busy_ready", 32'(busA.ReqReady), 32'd0);
      rstA = 1'b0;
      #1;
      check("mid_rst_ready",  32'(busA.ReqReady),  32'd1);
      check("mid_rst_rvalid", 32'(busA.RespValid), 32'd0);
      check("mid_rst_led",    32'(ledA),           32'd0);
      @(negedge Clk);
      rstA = 1'b1;
      txn(0, 1'b0, 32'h20, 32'd0, rd, err, lat, ledR);
      check("mid_ld20_rdata", rd, 32'h0);
      check("mid_ld20_lat",   32'(lat), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS pipeline: the memory end of the CPU's data-memory load/store interface. It accepts one word request at a time over a valid/ready handshake and inserts a programmable number of wait states. It serves requests from an internal word-addressed RAM or from two memory-mapped I/O registers: an 8-bit LED output and an 8-bit switch input. It sits between the M-stage address/write-data/write-enable signals and the board I/O.

## Interface
- ADDR_W, default 8: word-index bits of the RAM; depth is 2^ADDR_W words, byte range 0 .. 4·2^ADDR_W−1.
- WAIT_CYCLES, default 2: wait states between accept and response; legal range 0..15.
- LED_ADDR, default 32'hFFFF_FF00: byte address of the LED register (read/write).
- SW_ADDR, default 32'hFFFF_FF04: byte address of the switch register (read-only).

Ports (one clock; reset is asynchronous and active-low):
- Clk  in  1  sole clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  responder can accept; a transfer occurs when ReqValid && ReqReady at a rising edge.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddr  in  32  byte address.
- ReqWrData  in  32  store data.
- RespValid  out  1  one-cycle pulse; response fields are valid.
- RespRdData  out  32  load data; 0 for stores and errors.
- RespErr  out  1  access rejected.
- switch  in  8  asynchronous board switches.
- led  out  8  LED register.

## Operation
- FSM states:
  - IDLE: ReqReady=1.
  - BUSY: ReqReady=0; wait counter running.
  - RESP: ReqReady=0; RespValid=1.
- Transitions:
  - IDLE→BUSY on accept when WAIT_CYCLES>0.
  - IDLE→RESP on accept when WAIT_CYCLES=0.
  - BUSY→RESP when the counter reaches WAIT_CYCLES−1.
  - RESP→IDLE unconditionally.
- On accept, ReqWrite, ReqAddr and ReqWrData are latched. Request inputs are ignored outside IDLE.
- Address decode on the latched address, in priority order:
  - ReqAddr[1:0]≠0 → error.
  - LED_ADDR → LED register.
  - SW_ADDR → switch register; a store to it is an error.
  - Address < 4·2^ADDR_W → RAM word ReqAddr[ADDR_W+1:2].
  - Anything else → error.
- Loads:
  - RAM returns the stored word.
  - LED returns {24'b0, led}.
  - SW returns {24'b0, switch_sync}.
- Stores:
  - RAM writes the full word.
  - LED loads ReqWrData[7:0].
  - RespRdData=0.
- Errors: RespErr=1, RespRdData=0, no state change in RAM or LED.
- The store commit and the RespRdData/RespErr capture happen on the edge entering RESP.
- switch is resynchronised by two flops (switch_sync). A load samples switch_sync on the edge entering RESP.

## Timing
- Reset values:
  - FSM=IDLE, ReqReady=1.
  - RespValid=0, RespRdData=0, RespErr=0.
  - led=0, switch_sync=0, wait counter=0.
  - RAM contents are not reset.
- Latency:
  - Accept at edge 0 → RespValid high during cycle WAIT_CYCLES+1, for exactly one cycle.
  - Next accept is possible at the edge ending the RESP cycle+1. The earliest back-to-back accept is edge WAIT_CYCLES+2.
- RespRdData and RespErr hold their value after RespValid falls, until the next response.
- A load to an address stored by the immediately preceding request returns the new data.
- Reset mid-operation returns to IDLE immediately and discards the pending request.
  - A store is committed only if the edge entering RESP has already occurred.
- WAIT_CYCLES=0 gives 1-cycle latency; the BUSY state is never entered.
- The top RAM word (index 2^ADDR_W−1) is valid. The address 4·2^ADDR_W errors unless it matches an MMIO address.

## Structure
- Shared package mips_pkg:
  - state encoding typedef dmem_state_t (IDLE, BUSY, RESP);
  - default LED_ADDR and SW_ADDR constants.
- One natural sub-module, dmem_ram: a single-port synchronous word RAM with inputs Clk, we, addr[ADDR_W−1:0], wdata[31:0] and output rdata[31:0]. It has no reset and is inferred as block RAM.
- The FSM, decode, MMIO registers and switch synchroniser stay in dmem_responder.

## Test plan
- Store then load, default parameters:
  - store 32'hDEADBEEF to 0x10; RespValid in cycle 3, RespErr=0;
  - then load 0x10 → RespRdData=32'hDEADBEEF.
- Misaligned and out-of-range accesses:
  - store 32'h1 to 0x13 → RespErr=1; a subsequent load of 0x10 still returns DEADBEEF;
  - load 0x400 with ADDR_W=8 → RespErr=1, RespRdData=0.
- MMIO:
  - store 32'h0000_00A5 to LED_ADDR → led=8'hA5 from the RESP cycle;
  - switch=8'h3C held for 3 cycles, then load SW_ADDR → 32'h0000_003C;
  - store to SW_ADDR → RespErr=1.
- Handshake:
  - ReqValid held high continuously → ReqReady low during BUSY/RESP;
  - exactly one accept per WAIT_CYCLES+2 cycles; RespValid never wider than 1 cycle.
- WAIT_CYCLES=0: store/load to 0x0 → RespValid one cycle after each accept; data correct.
- Reset mid-operation: assert Rst low during BUSY of a store to 0x20 (old value 32'h0) →
  - ReqReady=1, RespValid=0 and led=0 immediately;
  - a later load of 0x20 returns 32'h0.
